// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin controlled 4:1 mux.
package mux_ctrl_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  typedef struct packed {
    logic             vld;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First asserted request scanning from ptr upward, modulo N_REQ.
  function automatic pick_t rr_pick(logic [N_REQ-1:0] req, logic [SEL_W-1:0] ptr);
    pick_t            r;
    logic [SEL_W-1:0] idx;
    r = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!r.vld && req[idx]) begin
        r.vld = 1'b1;
        r.idx = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between the requesters and the arbitrated mux.
interface mux4_rr_arbiter_if;
  import mux_ctrl_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] in;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] s;
  logic             y;
  logic             y_vld;

  modport master (output req, in, input gnt, s, y, y_vld);
  modport slave  (input req, in, output gnt, s, y, y_vld);
endinterface

// File: rtl/mux4x1.sv
// Plain 4:1 single-bit multiplexer.
module mux4x1
  import mux_ctrl_pkg::*;
(
  output logic             y,
  input  logic [N_REQ-1:0] in,
  input  logic [SEL_W-1:0] s
);
  assign y = in[s];
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with per-grant hold limit driving the select of a mux4x1.
module mux4_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] gnt, gnt_n;
  logic [SEL_W-1:0] s, s_n;
  logic             y_vld, y_vld_n;
  logic [N_REQ-1:0] req, in;
  logic             y;
  logic             done;
  pick_t            pick;

  assign req       = bus.req;
  assign in        = bus.in;
  assign bus.gnt   = gnt;
  assign bus.s     = s;
  assign bus.y_vld = y_vld;
  assign bus.y     = y;

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      s     <= '0;
      y_vld <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      s     <= s_n;
      y_vld <= y_vld_n;
    end
  end

  // Next state: arbitrate from idle, or release the owner (drop/expiry) and re-arbitrate.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    pick    = '0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        pick = rr_pick(req, ptr);
        if (pick.vld) begin
          state_n = GRANT;
          cnt_n   = CNT_W'(1);
        end
      end
      GRANT: begin
        done = !req[s] || (cnt == HOLD_MAX);
        if (done) begin
          ptr_n = s + SEL_W'(1);
          pick  = rr_pick(req, ptr_n);
          if (pick.vld) begin
            cnt_n = CNT_W'(1);
          end else begin
            state_n = IDLE;
          end
        end else if (cnt < HOLD_MAX) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode; select keeps its last value while idle.
  always_comb begin
    gnt_n   = gnt;
    s_n     = s;
    y_vld_n = y_vld;
    if (state_n == IDLE) begin
      gnt_n   = '0;
      y_vld_n = 1'b0;
    end else if (pick.vld) begin
      gnt_n   = N_REQ'(1) << pick.idx;
      s_n     = pick.idx;
      y_vld_n = 1'b1;
    end
  end

  mux4x1 u_mux (
    .y  (y),
    .in (in),
    .s  (s)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized bench for mux4_rr_arbiter (HOLD_CYCLES 4 and 1) against a grant-level model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;

  int vectors    = 0;
  int miscompares = 0;

  // Model state per DUT: owner (-1 idle), cycles held, priority pointer, last select.
  int hold[2] = '{4, 1};
  int m_own[2];
  int m_held[2];
  int m_ptr[2];
  int m_s[2];

  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus4 ();
  mux4_rr_arbiter_if bus1 ();

  assign bus4.req = req;
  assign bus4.in  = din;
  assign bus1.req = req;
  assign bus1.in  = din;

  mux4_rr_arbiter #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux4_rr_arbiter #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d]  = -1;
      m_held[d] = 0;
      m_ptr[d]  = 0;
      m_s[d]    = 0;
    end
  endtask

  function automatic int scan(input int p, input logic [3:0] r);
    for (int j = 0; j < 4; j++)
      if (r[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    for (int d = 0; d < 2; d++) begin
      if (m_own[d] >= 0 && req[m_own[d]] && m_held[d] < hold[d]) begin
        m_held[d]++;
      end else begin
        if (m_own[d] >= 0) m_ptr[d] = (m_own[d] + 1) % 4;
        w = scan(m_ptr[d], req);
        m_own[d] = w;
        if (w >= 0) begin
          m_held[d] = 1;
          m_s[d]    = w;
        end
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic y);
    logic [3:0] eg;
    eg = (m_own[d] < 0) ? 4'b0000 : 4'(1 << m_own[d]);
    check($sformatf("h%0d_gnt", hold[d]), 32'(g), 32'(eg));
    check($sformatf("h%0d_s", hold[d]), 32'(s), 32'(m_s[d]));
    check($sformatf("h%0d_y_vld", hold[d]), 32'(v), 32'(m_own[d] >= 0));
    check($sformatf("h%0d_y", hold[d]), 32'(y), 32'(din[m_s[d]]));
  endtask

  task automatic check_both();
    check_dut(0, bus4.gnt, bus4.s, bus4.y_vld, bus4.y);
    check_dut(1, bus1.gnt, bus1.s, bus1.y_vld, bus1.y);
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d);
    req = r;
    din = d;
    @(posedge clk);
    model_step();
    #1;
    check_both();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_both();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 4'b0110;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_both();
    din = 4'b0101;
    #1;
    check_both();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset and idle
    repeat (5) cycle(4'b0000, 4'($urandom));

    // Single requester
    cycle(4'b0100, 4'b0100);
    check("t2_gnt", 32'(bus4.gnt), 32'h4);
    check("t2_y", 32'(bus4.y), 32'h1);
    cycle(4'b0000, 4'b0100);
    check("t2_drop", 32'(bus4.gnt), 32'h0);

    // Full contention
    repeat (24) cycle(4'b1111, 4'($urandom));

    // Early drop
    async_reset();
    cycle(4'b0011, 4'($urandom));
    cycle(4'b0011, 4'($urandom));
    cycle(4'b0010, 4'($urandom));
    check("t4_move", 32'(bus4.gnt), 32'h2);
    repeat (3) cycle(4'b0011, 4'($urandom));

    // Two alternating requesters
    repeat (10) cycle(4'b1010, 4'($urandom));

    // Reset mid-grant
    repeat (2) cycle(4'b1000, 4'($urandom));
    #2;
    req = 4'b1001;
    async_reset();
    check("t6_rst_gnt", 32'(bus4.gnt), 32'h0);
    cycle(4'b1001, 4'($urandom));
    check("t6_first", 32'(bus4.gnt), 32'h1);

    // Random traffic with sticky requests and occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      r = req;
      case ($urandom_range(0, 3))
        0: r = 4'($urandom);
        1: r = r ^ (4'b0001 << $urandom_range(0, 3));
        default: ;
      endcase
      if ($urandom_range(0, 249) == 0) begin
        #2;
        async_reset();
      end
      cycle(r, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the single output line of the existing `mux4x1` between four requesters. It drives the mux select `s` from registered grant state and bounds each grant to a programmable number of cycles. Fairness holds under continuous contention. It sits directly in front of a `mux4x1` instance, which it owns.

## Interface

**Parameters**
- `HOLD_CYCLES`, default 4: maximum consecutive cycles a single grant may last; legal range 1..255.

**Ports**
- `clk` — in, 1 — rising-edge clock.
- `rst_n` — in, 1 — asynchronous active-low reset. This is the single clock and reset for the block.
- `req` — in, 4 — per-requester request, level-sensitive; bit i belongs to requester i.
- `in` — in, 4 — per-requester data bit, forwarded to the mux inputs.
- `gnt` — out, 4 — one-hot grant; all zero when idle.
- `s` — out, 2 — mux select, equal to the binary index of the current owner.
- `y` — out, 1 — mux output, `in[s]`, combinational from `in`.
- `y_vld` — out, 1 — high exactly when `gnt` is non-zero.

## Operation

- **State machine:** two states, `IDLE` and `GRANT`.
- **Priority pointer:** `ptr` is 2 bits. Arbitration picks the first asserted `req` bit scanning `ptr`, `ptr+1`, … modulo 4.
- **IDLE:**
  - If `req != 0`: next state is `GRANT`, `gnt` = one-hot of the winner, `s` = winner index, `cnt` = 1.
  - Otherwise: stay in `IDLE`; `gnt` = 0; `s` holds its last value.
- **GRANT, owner index o:**
  - **Release** when either `req[o]` = 0 (owner drops) or `cnt` = `HOLD_CYCLES` (grant expires).
  - **On release:** `ptr` = o+1 mod 4.
    - If any other `req` bit is set, re-arbitrate immediately using the new `ptr`. The next grant appears at the next edge with no idle bubble, and `cnt` = 1.
    - If only `req[o]` is still set, o is granted again, since it is the only requester.
    - If `req` = 0, go to `IDLE`.
  - **No release:** `cnt` increments; `gnt` and `s` are unchanged.
- **Counter:** `cnt` is 8 bits and saturates at `HOLD_CYCLES`; it never wraps.
- **Grant changes:** `gnt` changes only at clock edges and is never multi-hot.
- **`req` changes during a grant:** changes on non-owner bits do not affect the current grant.
- **Reset values:**
  - Outputs: `gnt` = 0000, `s` = 00, `y_vld` = 0, `y` = `in[0]`.
  - Internal: `ptr` = 0, `cnt` = 0, state `IDLE`.
- **Reset mid-grant:** grant is dropped asynchronously. The first grant after reset release starts scanning at index 0.

## Timing

- **Latency:** `req` sampled at edge k produces `gnt`/`s`/`y_vld` valid after edge k. Arbitration latency is 1 cycle.
- **Data path:** `y` follows `in[s]` combinationally in the same cycle; there is no pipeline register on data.
- **Owner drop:** owner deasserts `req` before edge k, so `gnt` changes after edge k. The owner may therefore see at most one cycle of grant after dropping.
- **Hold limit:** an owner holding `req` continuously is granted for exactly `HOLD_CYCLES` cycles, then yields if anyone else is requesting.
- **`HOLD_CYCLES` = 1:** pure round-robin; the grant rotates every cycle among active requesters.
- **Simultaneous events:** expiry and owner drop in the same cycle are treated as one release; the pointer advances once.

## Structure

- **Shared package `mux_ctrl_pkg`:**
  - `N_REQ` = 4 and `SEL_W` = 2.
  - State enum `{IDLE, GRANT}`.
  - Function `rr_pick(req, ptr)` returning a valid flag and a 2-bit index.
- **Sub-module:** the existing `mux4x1` instantiated once, with port connections `.y(y)`, `.in(in)`, `.s(s)`.
- **Arbiter logic:** the FSM, pointer and counter are local to the block; no further sub-modules.

## Test plan

1. **Reset and idle:** hold `rst_n` = 0, then release with `req` = 0000. Expect `gnt` = 0000, `s` = 00 and `y_vld` = 0 for 5 cycles.
2. **Single requester:** `req` = 0100 and `in` = 0100. After 1 edge expect `gnt` = 0100, `s` = 10, `y` = 1. Drop `req`; after the next edge expect `gnt` = 0000.
3. **Full contention:** `req` = 1111 with `HOLD_CYCLES` = 4. Expect grant order 0,1,2,3,0, each owner holding exactly 4 cycles with no gaps.
4. **Early drop:** `req` = 0011 and owner 0 drops after 2 cycles. Expect `gnt` to move 0001→0010 one edge after the drop, and `ptr` = 1.
5. **`HOLD_CYCLES` = 1:** `req` = 1010. Expect `gnt` to alternate 0010, 1000 every cycle, with `y` tracking `in[1]` and `in[3]`.
6. **Reset mid-grant:** `req` = 1000 and reset asserted while granted. Expect `gnt` = 0000 immediately (asynchronous). After release with `req` = 1001, expect the first grant = 0001.
